step_profile_gen: RTL and testbench
===================================

# step_profile_gen

Step-pulse generator for one stepper axis. It runs as the stage directly after the motion timing calculator and takes the same five-word motion parameter set (N, nn, t0, tna, delta). It emits N step pulses along a trapezoidal (or triangular) delay profile: accelerate, cruise, decelerate. Total motion time equals the calculator's tt result, so the two stages agree cycle-for-cycle.

## Interface
Parameters:
- PULSE_WIDTH, default 10: step high time in clk cycles.
- MIN_PERIOD, default 2*PULSE_WIDTH: floor on any step period, in cycles.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level-held motion request. Dropping it aborts or acknowledges.
- params  in  32 x [0:4]  word 0 = N (total steps), word 1 = nn (acceleration steps), word 2 = t0 (start delay), word 3 = tna (cruise delay), word 4 = delta (per-step delay change).
- dir_in  in  1  direction, latched at motion start.
- step  out  1  step pulse.
- dir  out  1  latched direction.
- busy  out  1  motion in progress.
- finish  out  1  motion complete. Held high until start drops.
- steps_done  out  32  count of step rising edges in the current motion.
- cur_delay  out  32  period applied to the current step.

## Operation
- FSM states: IDLE, LOAD, ACCEL, CRUISE, DECEL, DONE.
- IDLE → LOAD: start=1 while in IDLE. Latch params and dir_in.
- LOAD (one cycle) computes:
  - a = (N > 2·nn) ? nn : N>>1
  - cruise_cnt = N − 2a
  - cruise_delay = (N > 2·nn) ? tna : t0 − delta·a
  - ideal = t0
- LOAD exits: N=0 → DONE. a=0 → CRUISE. Otherwise → ACCEL.
- ACCEL: a steps with delays t0 − delta·k, k = 0..a−1. ideal decrements by delta after each step except the last.
- CRUISE: cruise_cnt steps at cruise_delay. Skipped if cruise_cnt = 0.
- DECEL: a steps, mirroring ACCEL. The first delay is the last ACCEL delay, then ideal increments by delta per step.
- Delay clamp:
  - ideal is a 34-bit signed register.
  - Applied period = max(MIN_PERIOD, ideal).
  - cruise_delay is clamped the same way, with the subtraction done in signed arithmetic.
  - The clamp keeps DECEL an exact mirror of ACCEL.
- Each step period: step=1 for the first PULSE_WIDTH cycles, then 0 for the remaining cycles of the period.
- After the last period of the last step: → DONE. finish=1, busy=0.
- DONE → IDLE when start=0. finish clears the same cycle.
- Abort: start=0 in LOAD/ACCEL/CRUISE/DECEL → IDLE next cycle. step=0, busy=0, finish=0. steps_done holds its value until the next LOAD clears it.
- Reset values (any state): IDLE, step=0, dir=0, busy=0, finish=0, steps_done=0, cur_delay=0. Reset has priority over start.
- Multiplies (delta·a, 2·nn) occur only in LOAD. Width is 32×32 truncated to 34 signed bits. Compare N > 2·nn in 33 bits so no wrap.

## Timing
- start sampled high at edge 0. LOAD in cycle 1. First step rises at edge 2 and busy=1 from the same edge.
- Consecutive step rising edges are exactly cur_delay cycles apart.
- finish rises exactly Σdelays cycles after the first step edge, i.e. edge 2 + tt.
- N=0: finish=1 at edge 2. No step pulses.
- steps_done increments on each step rising edge.
- cur_delay updates on the same edge as the step rising edge.
- Parameter changes during motion are ignored, since the values are latched in LOAD.

## Structure
- Package step_pkg holds:
  - the state enum
  - param index constants (P_N=0, P_NN=1, P_T0=2, P_TNA=3, P_DELTA=4)
  - the default PULSE_WIDTH and MIN_PERIOD
- One sub-module, step_period_timer:
  - loads a period
  - asserts pulse for PULSE_WIDTH cycles
  - raises period_done on the last cycle.
- The FSM, phase counters and the ideal register stay in the top level.

## Test plan
- Trapezoid: N=10, nn=3, t0=100, tna=60, delta=10.
  - Delays must be 100, 90, 80, 60×4, 80, 90, 100.
  - finish at edge 782. steps_done=10.
- Triangle, odd N: N=5, nn=3, t0=100, delta=10.
  - Delays must be 100, 90, 80, 90, 100.
  - finish at edge 462.
- Zero steps: N=0.
  - No step pulse. finish at edge 2.
  - Drop start → finish=0 next cycle.
- Clamp: N=8, nn=4, t0=50, delta=20, PULSE_WIDTH=10.
  - Delays must be 50, 30, 20, 20, 20, 20, 30, 50.
- Abort: drop start after the 3rd step rising edge of the trapezoid case.
  - Next cycle: step=0, busy=0, finish=0, steps_done=3.
  - Restart must replay the full profile from the beginning.
- Reset mid-CRUISE.
  - All outputs return to their reset values on the next edge.
  - With start still high, motion restarts: LOAD, then first step 2 cycles after reset deasserts.

Source files
------------

// File: rtl/step_pkg.sv
// rtl/step_pkg.sv - shared types, parameter indices and period clamp for the step profile generator
package step_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ACCEL,
    S_CRUISE,
    S_DECEL,
    S_DONE
  } state_e;

  localparam int P_N     = 0;
  localparam int P_NN    = 1;
  localparam int P_T0    = 2;
  localparam int P_TNA   = 3;
  localparam int P_DELTA = 4;

  localparam int DEF_PULSE_WIDTH = 10;
  localparam int DEF_MIN_PERIOD  = 2 * DEF_PULSE_WIDTH;

  // Floor a signed ideal delay at the minimum period; positive ideals always fit in 32 bits.
  function automatic logic [31:0] clamp_period(input logic signed [33:0] ideal,
                                               input logic [31:0] min_period);
    if (ideal < $signed({2'b00, min_period})) begin
      return min_period;
    end
    return ideal[31:0];
  endfunction

endpackage

// File: rtl/step_profile_gen_if.sv
// rtl/step_profile_gen_if.sv - motion request and step output bundle
interface step_profile_gen_if;
  logic        start;
  logic [31:0] params [0:4];
  logic        dir_in;
  logic        step;
  logic        dir;
  logic        busy;
  logic        finish;
  logic [31:0] steps_done;
  logic [31:0] cur_delay;

  modport master (
    output start, params, dir_in,
    input  step, dir, busy, finish, steps_done, cur_delay
  );

  modport slave (
    input  start, params, dir_in,
    output step, dir, busy, finish, steps_done, cur_delay
  );
endinterface

// File: rtl/step_period_timer.sv
// rtl/step_period_timer.sv - one step period: pulse for PULSE_WIDTH cycles, flag the last cycle
module step_period_timer #(
  parameter int PULSE_WIDTH = step_pkg::DEF_PULSE_WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic [31:0] period_i,
  output logic        pulse_o,
  output logic        period_done_o
);

  logic        active_q, active_d;
  logic [31:0] elapsed_q, elapsed_d;
  logic [31:0] period_q, period_d;

  // Load restarts the count at 1 so the period ends when elapsed equals the loaded period.
  always_comb begin
    active_d  = active_q;
    elapsed_d = elapsed_q;
    period_d  = period_q;
    if (clear_i) begin
      active_d  = 1'b0;
      elapsed_d = '0;
      period_d  = '0;
    end else if (load_i) begin
      active_d  = 1'b1;
      elapsed_d = 32'd1;
      period_d  = period_i;
    end else if (active_q) begin
      if (elapsed_q == period_q) begin
        active_d = 1'b0;
      end else begin
        elapsed_d = elapsed_q + 32'd1;
      end
    end
  end

  // Counter state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q  <= 1'b0;
      elapsed_q <= '0;
      period_q  <= '0;
    end else begin
      active_q  <= active_d;
      elapsed_q <= elapsed_d;
      period_q  <= period_d;
    end
  end

  assign pulse_o       = active_q && (elapsed_q <= 32'(PULSE_WIDTH));
  assign period_done_o = active_q && (elapsed_q == period_q);

endmodule

// File: rtl/step_profile_gen.sv
// rtl/step_profile_gen.sv - trapezoidal/triangular step pulse profile for one axis
module step_profile_gen #(
  parameter int PULSE_WIDTH = step_pkg::DEF_PULSE_WIDTH,
  parameter int MIN_PERIOD  = 2 * PULSE_WIDTH
) (
  input logic               clk,
  input logic               reset,
  step_profile_gen_if.slave bus
);
  import step_pkg::*;

  localparam logic [31:0] MIN_P = 32'(MIN_PERIOD);

  state_e state_q, state_d;

  logic [31:0] n_q, n_d, nn_q, nn_d, t0_q, t0_d, tna_q, tna_d, delta_q, delta_d;
  logic        dir_q, dir_d;
  logic [31:0] a_q, a_d, cruise_cnt_q, cruise_cnt_d, cruise_delay_q, cruise_delay_d;
  logic [31:0] phase_cnt_q, phase_cnt_d, steps_done_q, steps_done_d, cur_delay_q, cur_delay_d;
  logic signed [33:0] ideal_q, ideal_d;

  logic               long_move_c;
  logic [31:0]        a_c, cruise_cnt_c, cruise_delay_c;
  logic [33:0]        accel_drop_c;
  logic signed [33:0] t0_s, delta_s;
  logic [31:0]        a_sel, cruise_cnt_sel, cruise_delay_sel;
  logic               in_motion_d, launch_c, period_done, pulse;
  logic [31:0]        delay_c;

  // Phase split computed from the latched parameters; only registered when leaving LOAD.
  assign t0_s           = $signed({2'b00, t0_q});
  assign delta_s        = $signed({2'b00, delta_q});
  assign long_move_c    = {1'b0, n_q} > {nn_q, 1'b0};
  assign a_c            = long_move_c ? nn_q : (n_q >> 1);
  assign cruise_cnt_c   = n_q - (a_c << 1);
  assign accel_drop_c   = 34'(delta_q) * 34'(a_c);
  assign cruise_delay_c = long_move_c ? clamp_period($signed({2'b00, tna_q}), MIN_P)
                                      : clamp_period(t0_s - $signed(accel_drop_c), MIN_P);

  // While in LOAD the phase registers are not yet written, so steer the fresh values.
  assign a_sel            = (state_q == S_LOAD) ? a_c            : a_q;
  assign cruise_cnt_sel   = (state_q == S_LOAD) ? cruise_cnt_c   : cruise_cnt_q;
  assign cruise_delay_sel = (state_q == S_LOAD) ? cruise_delay_c : cruise_delay_q;
  assign in_motion_d      = (state_d == S_ACCEL) || (state_d == S_CRUISE) || (state_d == S_DECEL);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: phases advance only at the end of a step period.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_LOAD;
      S_LOAD: begin
        if (!bus.start)      state_d = S_IDLE;
        else if (n_q == '0)  state_d = S_DONE;
        else if (a_c == '0)  state_d = S_CRUISE;
        else                 state_d = S_ACCEL;
      end
      S_ACCEL: begin
        if (!bus.start) state_d = S_IDLE;
        else if (period_done) begin
          if (phase_cnt_q != '0)       state_d = S_ACCEL;
          else if (cruise_cnt_q != '0) state_d = S_CRUISE;
          else                         state_d = S_DECEL;
        end
      end
      S_CRUISE: begin
        if (!bus.start) state_d = S_IDLE;
        else if (period_done) begin
          if (phase_cnt_q != '0) state_d = S_CRUISE;
          else if (a_q != '0)    state_d = S_DECEL;
          else                   state_d = S_DONE;
        end
      end
      S_DECEL: begin
        if (!bus.start) state_d = S_IDLE;
        else if (period_done) begin
          if (phase_cnt_q != '0) state_d = S_DECEL;
          else                   state_d = S_DONE;
        end
      end
      S_DONE:  if (!bus.start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: latch on request, split phases on LOAD exit, pick each step's delay at launch.
  always_comb begin
    n_d            = n_q;
    nn_d           = nn_q;
    t0_d           = t0_q;
    tna_d          = tna_q;
    delta_d        = delta_q;
    dir_d          = dir_q;
    a_d            = a_q;
    cruise_cnt_d   = cruise_cnt_q;
    cruise_delay_d = cruise_delay_q;
    phase_cnt_d    = phase_cnt_q;
    steps_done_d   = steps_done_q;
    cur_delay_d    = cur_delay_q;
    ideal_d        = ideal_q;
    delay_c        = cur_delay_q;
    launch_c       = 1'b0;

    if ((state_q == S_IDLE) && (state_d == S_LOAD)) begin
      n_d          = bus.params[P_N];
      nn_d         = bus.params[P_NN];
      t0_d         = bus.params[P_T0];
      tna_d        = bus.params[P_TNA];
      delta_d      = bus.params[P_DELTA];
      dir_d        = bus.dir_in;
      steps_done_d = '0;
    end

    if ((state_q == S_LOAD) && (state_d != S_IDLE)) begin
      a_d            = a_c;
      cruise_cnt_d   = cruise_cnt_c;
      cruise_delay_d = cruise_delay_c;
      ideal_d        = t0_s;
    end

    launch_c = in_motion_d && ((state_q == S_LOAD) || period_done);

    if (launch_c) begin
      case (state_d)
        S_ACCEL: begin
          if (state_q == S_ACCEL) begin
            ideal_d     = ideal_q - delta_s;
            phase_cnt_d = phase_cnt_q - 32'd1;
          end else begin
            ideal_d     = t0_s;
            phase_cnt_d = a_sel - 32'd1;
          end
          delay_c = clamp_period(ideal_d, MIN_P);
        end
        S_CRUISE: begin
          delay_c     = cruise_delay_sel;
          phase_cnt_d = (state_q == S_CRUISE) ? (phase_cnt_q - 32'd1) : (cruise_cnt_sel - 32'd1);
        end
        S_DECEL: begin
          // First DECEL step reuses the last ACCEL ideal, so the profile mirrors exactly.
          if (state_q == S_DECEL) begin
            ideal_d     = ideal_q + delta_s;
            phase_cnt_d = phase_cnt_q - 32'd1;
          end else begin
            phase_cnt_d = a_sel - 32'd1;
          end
          delay_c = clamp_period(ideal_d, MIN_P);
        end
        default: delay_c = cur_delay_q;
      endcase
      steps_done_d = steps_done_q + 32'd1;
      cur_delay_d  = delay_c;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q            <= '0;
      nn_q           <= '0;
      t0_q           <= '0;
      tna_q          <= '0;
      delta_q        <= '0;
      dir_q          <= 1'b0;
      a_q            <= '0;
      cruise_cnt_q   <= '0;
      cruise_delay_q <= '0;
      phase_cnt_q    <= '0;
      steps_done_q   <= '0;
      cur_delay_q    <= '0;
      ideal_q        <= '0;
    end else begin
      n_q            <= n_d;
      nn_q           <= nn_d;
      t0_q           <= t0_d;
      tna_q          <= tna_d;
      delta_q        <= delta_d;
      dir_q          <= dir_d;
      a_q            <= a_d;
      cruise_cnt_q   <= cruise_cnt_d;
      cruise_delay_q <= cruise_delay_d;
      phase_cnt_q    <= phase_cnt_d;
      steps_done_q   <= steps_done_d;
      cur_delay_q    <= cur_delay_d;
      ideal_q        <= ideal_d;
    end
  end

  step_period_timer #(
    .PULSE_WIDTH(PULSE_WIDTH)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (state_d == S_IDLE),
    .load_i       (launch_c),
    .period_i     (delay_c),
    .pulse_o      (pulse),
    .period_done_o(period_done)
  );

  // FSM outputs.
  always_comb begin
    bus.step       = pulse;
    bus.dir        = dir_q;
    bus.busy       = (state_q == S_ACCEL) || (state_q == S_CRUISE) || (state_q == S_DECEL);
    bus.finish     = (state_q == S_DONE);
    bus.steps_done = steps_done_q;
    bus.cur_delay  = cur_delay_q;
  end

endmodule

// File: tb/tb_step_profile_gen.sv
// tb/tb_step_profile_gen.sv - self-checking bench for step_profile_gen
module tb_step_profile_gen;

  localparam int PW   = 10;
  localparam int MINP = 20;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   t0e = 0;
  bit   mon_on = 1'b0;
  bit   exp_dir = 1'b0;
  int   exp_d[$];
  int   n_checks = 0;
  int   n_fail = 0;

  step_profile_gen_if bus();

  step_profile_gen #(.PULSE_WIDTH(PW), .MIN_PERIOD(MINP)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Profile from first principles: ramp list, cruise run, ramp list reversed.
  task automatic build_model(input longint n, input longint nn, input longint t0,
                             input longint tna, input longint delta);
    longint a, cd, v;
    int acc[$];
    exp_d.delete();
    a = (n > 2 * nn) ? nn : n / 2;
    for (longint k = 0; k < a; k++) begin
      v = t0 - delta * k;
      acc.push_back(int'((v < MINP) ? MINP : v));
    end
    cd = (n > 2 * nn) ? tna : t0 - delta * a;
    if (cd < MINP) cd = MINP;
    foreach (acc[k]) exp_d.push_back(acc[k]);
    for (longint k = 0; k < n - 2 * a; k++) exp_d.push_back(int'(cd));
    for (int k = acc.size() - 1; k >= 0; k--) exp_d.push_back(acc[k]);
  endtask

  task automatic wait_rel(input int c);
    while ((cyc - t0e) < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_motion(input int n, input int nn, input int t0, input int tna,
                              input int delta, input bit d);
    build_model(n, nn, t0, tna, delta);
    bus.params[0] = n;
    bus.params[1] = nn;
    bus.params[2] = t0;
    bus.params[3] = tna;
    bus.params[4] = delta;
    bus.dir_in    = d;
    exp_dir       = d;
    @(posedge clk);
    #1;
    t0e       = cyc;
    bus.start = 1'b1;
    mon_on    = 1'b1;
  endtask

  task automatic end_motion();
    mon_on    = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("drop_finish", bus.finish, 0);
    chk("drop_busy", bus.busy, 0);
    chk("drop_step", bus.step, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_step"}, bus.step, 0);
    chk({tag, "_dir"}, bus.dir, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_finish"}, bus.finish, 0);
    chk({tag, "_steps_done"}, bus.steps_done, 0);
    chk({tag, "_cur_delay"}, bus.cur_delay, 0);
  endtask

  task automatic pin_model(input string tag, input int ref_d[$]);
    chk({tag, "_len"}, exp_d.size(), ref_d.size());
    foreach (ref_d[k]) begin
      if (k < exp_d.size()) chk($sformatf("%s_d%0d", tag, k), exp_d[k], ref_d[k]);
    end
  endtask

  // Every cycle of an active motion: expected outputs follow from step rise times 2 + sum of prior delays.
  always @(negedge clk) begin : monitor
    int c, i, tt, r_last;
    if (mon_on) begin
      c = cyc - t0e;
      if (c >= 1) begin
        tt = 0;
        i = 0;
        r_last = 0;
        foreach (exp_d[j]) begin
          if (2 + tt <= c) begin
            i = j + 1;
            r_last = 2 + tt;
          end
          tt += exp_d[j];
        end
        chk($sformatf("steps_done@%0d", c), bus.steps_done, i);
        chk($sformatf("step@%0d", c), bus.step, (i > 0 && (c - r_last) < PW && c < 2 + tt) ? 1 : 0);
        chk($sformatf("busy@%0d", c), bus.busy, (c >= 2 && c < 2 + tt) ? 1 : 0);
        chk($sformatf("finish@%0d", c), bus.finish, (c >= 2 + tt) ? 1 : 0);
        chk($sformatf("dir@%0d", c), bus.dir, exp_dir);
        if (i > 0) chk($sformatf("cur_delay@%0d", c), bus.cur_delay, exp_d[i-1]);
      end
    end
  end

  initial begin
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.dir_in = 1'b0;
    for (int k = 0; k < 5; k++) bus.params[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Trapezoid, with parameter and direction changes mid-motion that must be ignored.
    start_motion(10, 3, 100, 60, 10, 1'b1);
    pin_model("model_trap", '{100, 90, 80, 60, 60, 60, 60, 80, 90, 100});
    wait_rel(5);
    bus.params[0] = 3;
    bus.params[2] = 7;
    bus.params[4] = 1;
    bus.dir_in    = 1'b0;
    wait_rel(781);
    chk("trap_finish_781", bus.finish, 0);
    wait_rel(782);
    chk("trap_finish_782", bus.finish, 1);
    chk("trap_steps_done", bus.steps_done, 10);
    wait_rel(784);
    end_motion();

    // Abort after the third step edge, then a full replay.
    start_motion(10, 3, 100, 60, 10, 1'b0);
    wait_rel(192);
    chk("abort_pre_steps", bus.steps_done, 3);
    mon_on    = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_step", bus.step, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_finish", bus.finish, 0);
    chk("abort_steps_done", bus.steps_done, 3);
    repeat (2) @(posedge clk);
    #1;
    start_motion(10, 3, 100, 60, 10, 1'b1);
    wait_rel(784);
    chk("replay_steps_done", bus.steps_done, 10);
    end_motion();

    // Reset in the middle of CRUISE with start still held.
    start_motion(10, 3, 100, 60, 10, 1'b1);
    wait_rel(400);
    mon_on = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outputs("midreset");
    reset  = 1'b0;
    t0e    = cyc;
    mon_on = 1'b1;
    wait_rel(1);
    chk("rst_load_step", bus.step, 0);
    wait_rel(2);
    chk("rst_first_step", bus.step, 1);
    wait_rel(784);
    end_motion();

    // Triangle with odd N.
    start_motion(5, 3, 100, 60, 10, 1'b0);
    pin_model("model_tri", '{100, 90, 80, 90, 100});
    wait_rel(461);
    chk("tri_finish_461", bus.finish, 0);
    wait_rel(462);
    chk("tri_finish_462", bus.finish, 1);
    wait_rel(464);
    end_motion();

    // Clamp at the minimum period.
    start_motion(8, 4, 50, 999, 20, 1'b1);
    pin_model("model_clamp", '{50, 30, 20, 20, 20, 20, 30, 50});
    wait_rel(244);
    chk("clamp_steps_done", bus.steps_done, 8);
    end_motion();

    // Zero steps.
    start_motion(0, 3, 100, 60, 10, 1'b0);
    wait_rel(1);
    chk("zero_finish_1", bus.finish, 0);
    wait_rel(2);
    chk("zero_finish_2", bus.finish, 1);
    chk("zero_step", bus.step, 0);
    wait_rel(5);
    chk("zero_steps_done", bus.steps_done, 0);
    end_motion();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
